// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM states and flag bit positions shared by ula_seq and ula_core.
package ula_pkg;
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_COMP  = 4'd2;
   localparam logic [3:0] OP_IGUAL = 4'd3;
   localparam logic [3:0] OP_MAIOR = 4'd4;
   localparam logic [3:0] OP_MENOR = 4'd5;
   localparam logic [3:0] OP_AND   = 4'd6;
   localparam logic [3:0] OP_OR    = 4'd7;
   localparam logic [3:0] OP_MUL   = 4'd8;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
   function automatic logic is_reserved(input logic [3:0] op);
      return op > OP_MUL;
   endfunction
endpackage

// File: rtl/ula_core.sv
// ula_core: combinational single-cycle opcodes 0..7; reserved and MUL codes yield zero.
// Carry/overflow ports exist only when ULA_FLAGS_EN is defined.
module ula_core import ula_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
`ifdef ULA_FLAGS_EN
   output logic             carry,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] res,
   output logic             status
);
   always_comb begin
      res = '0;
      status = 1'b0;
      case (sel)
         OP_ADD:   res = a + b;
         OP_SUB:   res = a - b;
         OP_COMP:  res = '0 - b;
         OP_IGUAL: status = a == b;
         OP_MAIOR: begin status = a > b; res = status ? a : b; end
         OP_MENOR: begin status = a < b; res = status ? a : b; end
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         default:  res = '0;
      endcase
   end
`ifdef ULA_FLAGS_EN
   logic [WIDTH:0] sum, dif;
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};
   always_comb begin
      carry = 1'b0;
      ovf = 1'b0;
      if (sel == OP_ADD) begin
         carry = sum[WIDTH];
         ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (sel == OP_SUB) begin
         carry = dif[WIDTH];
         ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
   end
`endif
endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ALU with IDLE/CALC/DONE FSM and WIDTH-cycle shift-add multiplier.
// Optional ULA_FLAGS_EN adds the registered {N,Z,C,V} flagsULA output.
module ula_seq import ula_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clockULA,
   input  logic             resetULA,
   input  logic             startULA,
   input  logic [WIDTH-1:0] aULA,
   input  logic [WIDTH-1:0] bULA,
   input  logic [3:0]       selectULA,
   output logic             busyULA,
   output logic             doneULA,
   output logic [WIDTH-1:0] output0ULA,
   output logic [WIDTH-1:0] output1ULA,
`ifdef ULA_FLAGS_EN
   output logic [3:0]       flagsULA,
`endif
   output logic             statusULA,
   output logic             errorULA
);
   state_t state, state_n;
   logic [WIDTH-1:0] a_r, core_res, res0_n, res1_n;
   logic [2*WIDTH-1:0] prod, prod_step;
   logic [WIDTH:0] step_sum;
   logic [5:0] cnt;
   logic core_st, accept, last, wr;
`ifdef ULA_FLAGS_EN
   logic core_c, core_v;
   logic [3:0] flags_n;
`endif
   ula_core #(.WIDTH(WIDTH)) u_core (
      .a(aULA), .b(bULA), .sel(selectULA),
`ifdef ULA_FLAGS_EN
      .carry(core_c), .ovf(core_v),
`endif
      .res(core_res), .status(core_st)
   );
   assign accept = startULA && state != S_CALC;
   assign last = cnt == 6'(WIDTH - 1);
   assign busyULA = state == S_CALC;
   assign doneULA = state == S_DONE;
   // prod holds {partial product, remaining multiplier bits}; each step adds A and shifts right
   assign step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_r} : '0);
   assign prod_step = {step_sum, prod[WIDTH-1:1]};
   always_comb begin
      state_n = accept ? (selectULA == OP_MUL ? S_CALC : S_DONE)
              : state == S_CALC ? (last ? S_DONE : S_CALC) : S_IDLE;
      wr = (accept && selectULA != OP_MUL) || (state == S_CALC && last);
      res0_n = state == S_CALC ? prod_step[WIDTH-1:0] : core_res;
      res1_n = state == S_CALC ? prod_step[2*WIDTH-1:WIDTH] : '0;
   end
`ifdef ULA_FLAGS_EN
   always_comb begin
      flags_n = '0;
      flags_n[FLAG_N] = res0_n[WIDTH-1];
      flags_n[FLAG_Z] = res0_n == '0 && res1_n == '0;
      flags_n[FLAG_C] = state != S_CALC && core_c;
      flags_n[FLAG_V] = state != S_CALC && core_v;
   end
`endif
   always_ff @(posedge clockULA or posedge resetULA) begin
      if (resetULA) begin
         state <= S_IDLE;
         a_r <= '0;
         prod <= '0;
         cnt <= '0;
         output0ULA <= '0;
         output1ULA <= '0;
         statusULA <= 1'b0;
         errorULA <= 1'b0;
`ifdef ULA_FLAGS_EN
         flagsULA <= '0;
`endif
      end else begin
         state <= state_n;
         if (accept) begin
            a_r <= aULA;
            prod <= {{WIDTH{1'b0}}, bULA};
            cnt <= '0;
            errorULA <= is_reserved(selectULA);
         end else if (state == S_CALC) begin
            prod <= prod_step;
            cnt <= cnt + 6'd1;
         end
         if (wr) begin
            output0ULA <= res0_n;
            output1ULA <= res1_n;
            statusULA <= state != S_CALC && core_st;
`ifdef ULA_FLAGS_EN
            flagsULA <= flags_n;
`endif
         end
      end
   end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: scoreboard bench for ula_seq (WIDTH=8); flag checks compiled in with ULA_FLAGS_EN.
module tb_ula_seq;
   typedef struct packed {logic [7:0] o0; logic [7:0] o1; logic st; logic er;} res_t;
   logic clk = 0, rst = 1, start = 0;
   logic [7:0] a = 0, b = 0, o0, o1;
   logic [3:0] sel = 0;
   logic busy, done, status, error;
`ifdef ULA_FLAGS_EN
   logic [3:0] flags;
`endif
   res_t sb[$];
   int checks = 0, errors = 0;
   ula_seq #(.WIDTH(8)) dut (
      .clockULA(clk), .resetULA(rst), .startULA(start), .aULA(a), .bULA(b),
      .selectULA(sel), .busyULA(busy), .doneULA(done), .output0ULA(o0), .output1ULA(o1),
`ifdef ULA_FLAGS_EN
      .flagsULA(flags),
`endif
      .statusULA(status), .errorULA(error)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   function automatic res_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      res_t r = '0;
      logic [15:0] p;
      case (op)
         4'd0: r.o0 = x + y;
         4'd1: r.o0 = x - y;
         4'd2: r.o0 = 8'd0 - y;
         4'd3: r.st = x == y;
         4'd4: begin r.st = x > y; r.o0 = (x > y) ? x : y; end
         4'd5: begin r.st = x < y; r.o0 = (x < y) ? x : y; end
         4'd6: r.o0 = x & y;
         4'd7: r.o0 = x | y;
         4'd8: begin p = 16'(x) * 16'(y); r.o0 = p[7:0]; r.o1 = p[15:8]; end
         default: r.er = 1'b1;
      endcase
      return r;
   endfunction
   // called at a negedge; returns just after the accepting edge with inputs scrambled
   task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      start = 1; sel = op; a = x; b = y;
      sb.push_back(model(op, x, y));
      @(posedge clk); #1;
      start = 0; a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
   endtask
   task automatic collect(output res_t got, output int lat, output int bsy);
      lat = 0; bsy = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (busy) bsy++;
         if (done) begin lat = n; break; end
      end
      got = {o0, o1, status, error};
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if ({busy, done, o0, o1, status, error} !== 20'd0) begin errors++; $display("FAIL reset_state got %h want 0", {busy, done, o0, o1, status, error}); end
`ifdef ULA_FLAGS_EN
      checks++; if (flags !== 4'd0) begin errors++; $display("FAIL reset_flags got %h want 0", flags); end
`endif
      rst = 0;
   endtask
   task automatic test_add_sub;
      res_t got, exp;
      int lat, bsy;
      logic [3:0] ops [3] = '{4'd0, 4'd1, 4'd0};
      logic [7:0] xs [3] = '{8'hF0, 8'h05, 8'h7F};
      logic [7:0] ys [3] = '{8'h20, 8'h07, 8'h01};
      logic [7:0] want [3] = '{8'h10, 8'hFE, 8'h80};
      logic [3:0] fl [3] = '{4'b0010, 4'b1010, 4'b1001};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         issue(ops[i], xs[i], ys[i]);
         collect(got, lat, bsy);
         exp = sb.pop_front();
         checks++; if (lat !== 1 || bsy !== 0) begin errors++; $display("FAIL addsub_latency[%0d] got lat %0d busy %0d want 1/0", i, lat, bsy); end
         checks++; if (got !== exp || got.o0 !== want[i]) begin errors++; $display("FAIL addsub_result[%0d] got %h want %h", i, got, exp); end
`ifdef ULA_FLAGS_EN
         checks++; if (flags !== fl[i]) begin errors++; $display("FAIL addsub_flags[%0d] got %b want %b", i, flags, fl[i]); end
`else
         if (fl[i] === 4'bxxxx) $display("unused flag vector");
`endif
      end
   endtask
   task automatic test_mul;
      res_t got, exp;
      int lat = 0, bsy = 0;
      @(negedge clk);
      issue(4'd8, 8'd200, 8'd3);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         start = (n == 3);
         if (n == 3) begin sel = 4'd0; a = 8'd1; b = 8'd1; end
         if (busy) bsy++;
         if (done) begin lat = n; break; end
      end
      start = 0;
      got = {o0, o1, status, error};
      exp = sb.pop_front();
      checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got %0d want 9", lat); end
      checks++; if (bsy !== 8) begin errors++; $display("FAIL mul_busy_cycles got %0d want 8", bsy); end
      checks++; if (got !== exp || {got.o1, got.o0} !== 16'h0258) begin errors++; $display("FAIL mul_result got %h want %h", got, exp); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_ignored_start got done %b busy %b want 0/0", done, busy); end
   endtask
   task automatic test_back_to_back;
      res_t got, exp;
      int lat, bsy;
      @(negedge clk);
      issue(4'd4, 8'd9, 8'd12);
      collect(got, lat, bsy);
      exp = sb.pop_front();
      checks++; if (got !== exp || got.o0 !== 8'd12 || got.st !== 1'b0) begin errors++; $display("FAIL maior_result got %h want %h", got, exp); end
      issue(4'd5, 8'd9, 8'd12);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got done %b want 1", done); end
      collect(got, lat, bsy);
      exp = sb.pop_front();
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_latency got %0d want 1", lat); end
      checks++; if (got !== exp || got.o0 !== 8'd9 || got.st !== 1'b1) begin errors++; $display("FAIL menor_result got %h want %h", got, exp); end
   endtask
   task automatic test_random;
      res_t got, exp;
      int lat, bsy;
      logic [3:0] op;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         op = 4'($urandom_range(0, 15));
         issue(op, 8'($urandom), 8'($urandom));
         collect(got, lat, bsy);
         exp = sb.pop_front();
         checks++; if (lat !== ((op == 4'd8) ? 9 : 1)) begin errors++; $display("FAIL rand_latency[%0d] op %0d got %0d", i, op, lat); end
         checks++; if (got !== exp) begin errors++; $display("FAIL rand_result[%0d] op %0d got %h want %h", i, op, got, exp); end
      end
   endtask
   task automatic test_reserved;
      res_t got, exp;
      int lat, bsy;
      @(negedge clk);
      issue(4'd12, 8'h55, 8'hAA);
      collect(got, lat, bsy);
      exp = sb.pop_front();
      checks++; if (got !== exp || got !== 18'h00001) begin errors++; $display("FAIL reserved_result got %h want %h", got, exp); end
      @(negedge clk);
      issue(4'd3, 8'h33, 8'h33);
      collect(got, lat, bsy);
      exp = sb.pop_front();
      checks++; if (got !== exp || got.er !== 1'b0 || got.st !== 1'b1) begin errors++; $display("FAIL igual_clears_error got %h want %h", got, exp); end
   endtask
   task automatic test_reset_mid_mul;
      res_t got, exp;
      int lat, bsy;
      @(negedge clk);
      issue(4'd8, 8'd200, 8'd3);
      repeat (4) @(negedge clk);
      #1 rst = 1;
      #1;
      checks++; if ({busy, done, o0, o1, status, error} !== 20'd0) begin errors++; $display("FAIL reset_mid_mul_outputs got %h want 0", {busy, done, o0, o1, status, error}); end
      void'(sb.pop_back());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_mul_no_done got %b want 0", done); end
      end
      rst = 0;
      issue(4'd0, 8'd1, 8'd1);
      collect(got, lat, bsy);
      exp = sb.pop_front();
      checks++; if (lat !== 1 || got !== exp || got.o0 !== 8'd2) begin errors++; $display("FAIL post_reset_add got %h lat %0d want %h lat 1", got, lat, exp); end
   endtask
   initial begin
      test_reset;
      test_add_sub;
      test_mul;
      test_back_to_back;
      test_random;
      test_reserved;
      test_reset_mid_mul;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
